if_id_pipe: RTL and testbench

- Parametrised IF/ID pipeline register with valid/ready handshaking on both sides, a stall input, a flush input, and an optional one-entry skid buffer.
- Sits between the fetch unit (PC and instruction from memory) and the decoder.
- Replaces the fixed-width IF/ID register that had only hold/zero behaviour. Adds back-pressure, NOP insertion on flush, and occupancy reporting.

---
 rtl/if_id_pipe_if.sv | 34 +++
 rtl/if_id_pipe.sv | 132 +++++++++++++
 tb/tb_if_id_pipe.sv | 259 +++++++++++++++++++++++++
 3 files changed

// File: rtl/if_id_pipe_if.sv
`default_nettype none
// ============================================================================
// Module   : if_id_pipe_if
// Purpose  : Fetch/decode handshake bundle for the IF/ID pipeline register.
// Revision : 1.0 - initial release
// ============================================================================
interface if_id_pipe_if #(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
);
    logic              i_valid;
    logic              o_ready;
    logic [ADDR_W-1:0] i_pc_addr;
    logic [DATA_W-1:0] i_inst_data;
    logic              i_stall;
    logic              i_flush;
    logic              i_ready;
    logic              o_valid;
    logic [ADDR_W-1:0] o_pc_addr;
    logic [DATA_W-1:0] o_inst_data;
    logic [1:0]        o_count;

    // master = fetch/decode environment, slave = the pipeline register
    modport master (
        output i_valid, i_pc_addr, i_inst_data, i_stall, i_flush, i_ready,
        input  o_ready, o_valid, o_pc_addr, o_inst_data, o_count
    );

    modport slave (
        input  i_valid, i_pc_addr, i_inst_data, i_stall, i_flush, i_ready,
        output o_ready, o_valid, o_pc_addr, o_inst_data, o_count
    );
endinterface
`default_nettype wire

// File: rtl/if_id_pipe.sv
`default_nettype none
// ============================================================================
// Module   : if_id_pipe
// Purpose  : IF/ID pipeline register with valid/ready, stall, flush and an
//            optional one-entry skid buffer that registers the upstream ready.
// Revision : 1.0 - initial release
// ============================================================================
module if_id_pipe #(
    parameter int              ADDR_W   = 32,
    parameter int              DATA_W   = 32,
    parameter logic [DATA_W-1:0] NOP_INST = 32'h00000013,
    parameter bit              SKID_EN  = 1'b1
) (
    input logic         i_Clk,
    input logic         i_reset,
    if_id_pipe_if.slave io
);
    logic              r_main_valid;
    logic [ADDR_W-1:0] r_main_pc;
    logic [DATA_W-1:0] r_main_inst;

    logic              w_skid_valid;
    logic [ADDR_W-1:0] w_skid_pc;
    logic [DATA_W-1:0] w_skid_inst;

    logic              w_main_valid_nxt;
    logic [ADDR_W-1:0] w_main_pc_nxt;
    logic [DATA_W-1:0] w_main_inst_nxt;
    logic              w_skid_valid_nxt;
    logic [ADDR_W-1:0] w_skid_pc_nxt;
    logic [DATA_W-1:0] w_skid_inst_nxt;

    logic w_ready;
    logic w_out_ready;
    logic w_out_fire;
    logic w_in_fire;
    logic w_main_load;

    assign w_out_ready = io.i_ready & ~io.i_stall;
    assign w_out_fire  = r_main_valid & w_out_ready;
    assign w_in_fire   = io.i_valid & w_ready;
    assign w_main_load = ~r_main_valid | w_out_fire;

    always_comb begin
        w_main_valid_nxt = r_main_valid;
        w_main_pc_nxt    = r_main_pc;
        w_main_inst_nxt  = r_main_inst;
        w_skid_valid_nxt = w_skid_valid;
        w_skid_pc_nxt    = w_skid_pc;
        w_skid_inst_nxt  = w_skid_inst;

        // The skid entry is always older than the input, so it refills main first.
        if (w_main_load) begin
            if (w_skid_valid) begin
                w_main_valid_nxt = 1'b1;
                w_main_pc_nxt    = w_skid_pc;
                w_main_inst_nxt  = w_skid_inst;
                w_skid_valid_nxt = 1'b0;
            end else if (w_in_fire) begin
                w_main_valid_nxt = 1'b1;
                w_main_pc_nxt    = io.i_pc_addr;
                w_main_inst_nxt  = io.i_inst_data;
            end else begin
                w_main_valid_nxt = 1'b0;
            end
        end

        if (w_in_fire && !(w_main_load && !w_skid_valid)) begin
            w_skid_valid_nxt = 1'b1;
            w_skid_pc_nxt    = io.i_pc_addr;
            w_skid_inst_nxt  = io.i_inst_data;
        end

        if (io.i_flush) begin
            w_main_valid_nxt = 1'b0;
            w_skid_valid_nxt = 1'b0;
        end
    end

    always_ff @(posedge i_Clk or posedge i_reset) begin
        if (i_reset) begin
            r_main_valid <= 1'b0;
            r_main_pc    <= '0;
            r_main_inst  <= NOP_INST;
        end else begin
            r_main_valid <= w_main_valid_nxt;
            r_main_pc    <= w_main_pc_nxt;
            r_main_inst  <= w_main_inst_nxt;
        end
    end

    generate
        if (SKID_EN) begin : g_skid
            logic              r_skid_valid;
            logic [ADDR_W-1:0] r_skid_pc;
            logic [DATA_W-1:0] r_skid_inst;
            logic              r_ready;

            always_ff @(posedge i_Clk or posedge i_reset) begin
                if (i_reset) begin
                    r_skid_valid <= 1'b0;
                    r_skid_pc    <= '0;
                    r_skid_inst  <= '0;
                    r_ready      <= 1'b1;
                end else begin
                    r_skid_valid <= w_skid_valid_nxt;
                    r_skid_pc    <= w_skid_pc_nxt;
                    r_skid_inst  <= w_skid_inst_nxt;
                    r_ready      <= ~w_skid_valid_nxt;
                end
            end

            assign w_skid_valid = r_skid_valid;
            assign w_skid_pc    = r_skid_pc;
            assign w_skid_inst  = r_skid_inst;
            assign w_ready      = r_ready;
        end else begin : g_no_skid
            assign w_skid_valid = 1'b0;
            assign w_skid_pc    = '0;
            assign w_skid_inst  = '0;
            assign w_ready      = ~r_main_valid | w_out_ready;
        end
    endgenerate

    // Invalid output never exposes stale payload.
    assign io.o_valid     = r_main_valid;
    assign io.o_pc_addr   = r_main_valid ? r_main_pc : '0;
    assign io.o_inst_data = r_main_valid ? r_main_inst : NOP_INST;
    assign io.o_ready     = w_ready;
    assign io.o_count     = {1'b0, r_main_valid} + {1'b0, w_skid_valid};
endmodule
`default_nettype wire

// File: tb/tb_if_id_pipe.sv
`default_nettype none
// ============================================================================
// Module   : tb_if_id_pipe
// Purpose  : Queue-model bench driving a SKID_EN=0 and a SKID_EN=1 instance.
// Revision : 1.0 - initial release
// ============================================================================
module tb_if_id_pipe;
    localparam logic [31:0] c_NOP = 32'h00000013;

    typedef struct {
        logic [31:0] pc;
        logic [31:0] inst;
    } entry_t;

    logic i_Clk;
    logic i_reset;
    logic check_en;
    int   n_cmp;
    int   n_err;

    // index k of every vector selects the instance built with SKID_EN = k
    logic [1:0]        d_valid, d_stall, d_flush, d_ready;
    logic [1:0][31:0]  d_pc, d_inst;
    logic [1:0]        t_valid, t_ready;
    logic [1:0][31:0]  t_pc, t_inst;
    logic [1:0][1:0]   t_count;

    entry_t mq0[$];
    entry_t mq1[$];
    entry_t wq[$];

    if_id_pipe_if #(.ADDR_W(32), .DATA_W(32)) bus0 ();
    if_id_pipe_if #(.ADDR_W(32), .DATA_W(32)) bus1 ();

    if_id_pipe #(.ADDR_W(32), .DATA_W(32), .NOP_INST(c_NOP), .SKID_EN(1'b0)) u_dut0 (
        .i_Clk   (i_Clk),
        .i_reset (i_reset),
        .io      (bus0.slave)
    );

    if_id_pipe #(.ADDR_W(32), .DATA_W(32), .NOP_INST(c_NOP), .SKID_EN(1'b1)) u_dut1 (
        .i_Clk   (i_Clk),
        .i_reset (i_reset),
        .io      (bus1.slave)
    );

    assign bus0.i_valid     = d_valid[0];
    assign bus0.i_pc_addr   = d_pc[0];
    assign bus0.i_inst_data = d_inst[0];
    assign bus0.i_stall     = d_stall[0];
    assign bus0.i_flush     = d_flush[0];
    assign bus0.i_ready     = d_ready[0];
    assign bus1.i_valid     = d_valid[1];
    assign bus1.i_pc_addr   = d_pc[1];
    assign bus1.i_inst_data = d_inst[1];
    assign bus1.i_stall     = d_stall[1];
    assign bus1.i_flush     = d_flush[1];
    assign bus1.i_ready     = d_ready[1];

    assign t_valid = {bus1.o_valid, bus0.o_valid};
    assign t_ready = {bus1.o_ready, bus0.o_ready};
    assign t_pc    = {bus1.o_pc_addr, bus0.o_pc_addr};
    assign t_inst  = {bus1.o_inst_data, bus0.o_inst_data};
    assign t_count = {bus1.o_count, bus0.o_count};

    initial i_Clk = 1'b0;
    always #5 i_Clk = ~i_Clk;

    task automatic chk(input string name, input int k, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s skid=%0d: got %h expected %h at %0t", name, k, act, exp, $time);
        end
    endtask

    task automatic tick;
        @(posedge i_Clk);
        #1;
    endtask

    task automatic drive_all(input logic v, input logic [31:0] pc, input logic s,
                             input logic f, input logic r);
        d_valid = {2{v}};
        d_pc    = {pc, pc};
        d_inst  = {pc ^ 32'hA5A5_0000, pc ^ 32'hA5A5_0000};
        d_stall = {2{s}};
        d_flush = {2{f}};
        d_ready = {2{r}};
    endtask

    // Model: the held pairs form a FIFO (depth 1 + SKID_EN); outputs show its head.
    always @(negedge i_Clk) begin
        for (int k = 0; k < 2; k++) begin
            int          sz;
            logic        e_ready;
            logic        fo;
            logic        fi;
            entry_t      e;
            if (k == 0) wq = mq0;
            else        wq = mq1;
            sz = wq.size();
            if (k == 1) e_ready = (sz < 2);
            else        e_ready = (sz == 0) || (d_ready[k] && !d_stall[k]);

            if (check_en && !i_reset) begin
                chk("valid", k, {31'd0, t_valid[k]}, {31'd0, sz > 0});
                chk("pc",    k, t_pc[k],   (sz > 0) ? wq[0].pc   : 32'd0);
                chk("inst",  k, t_inst[k], (sz > 0) ? wq[0].inst : c_NOP);
                chk("count", k, {30'd0, t_count[k]}, sz);
                chk("ready", k, {31'd0, t_ready[k]}, {31'd0, e_ready});
            end

            if (i_reset || d_flush[k]) begin
                wq.delete();
            end else begin
                fo = (sz > 0) && d_ready[k] && !d_stall[k];
                fi = d_valid[k] && e_ready;
                if (fo) void'(wq.pop_front());
                if (fi) begin
                    e.pc   = d_pc[k];
                    e.inst = d_inst[k];
                    wq.push_back(e);
                end
            end
            if (k == 0) mq0 = wq;
            else        mq1 = wq;
        end
    end

    initial begin
        n_cmp    = 0;
        n_err    = 0;
        check_en = 1'b0;
        i_reset  = 1'b1;
        drive_all(1'b0, 32'h0, 1'b0, 1'b0, 1'b1);
        repeat (3) tick();
        for (int k = 0; k < 2; k++) begin
            chk("rst_valid", k, {31'd0, t_valid[k]}, 32'd0);
            chk("rst_pc",    k, t_pc[k], 32'd0);
            chk("rst_inst",  k, t_inst[k], c_NOP);
            chk("rst_count", k, {30'd0, t_count[k]}, 32'd0);
        end
        i_reset  = 1'b0;
        check_en = 1'b1;
        tick();
        chk("post_rst_ready", 1, {31'd0, t_ready[1]}, 32'd1);

        // streaming 0x0, 0x4, 0x8
        for (int i = 0; i < 3; i++) begin
            drive_all(1'b1, 32'(i * 4), 1'b0, 1'b0, 1'b1);
            tick();
            chk("stream_pc",    1, t_pc[1], 32'(i * 4));
            chk("stream_count", 1, {30'd0, t_count[1]}, 32'd1);
            chk("stream_ready", 1, {31'd0, t_ready[1]}, 32'd1);
            chk("stream_pc",    0, t_pc[0], 32'(i * 4));
        end
        drive_all(1'b0, 32'h0, 1'b0, 1'b0, 1'b1);
        repeat (2) tick();

        // back-pressure fills main + skid, then drains in order
        drive_all(1'b1, 32'h10, 1'b1, 1'b0, 1'b1);
        tick();
        drive_all(1'b1, 32'h14, 1'b1, 1'b0, 1'b1);
        tick();
        chk("bp_count", 1, {30'd0, t_count[1]}, 32'd2);
        chk("bp_ready", 1, {31'd0, t_ready[1]}, 32'd0);
        drive_all(1'b1, 32'h18, 1'b1, 1'b0, 1'b1);
        tick();
        chk("bp_hold_pc",    1, t_pc[1], 32'h10);
        chk("bp_hold_count", 1, {30'd0, t_count[1]}, 32'd2);
        drive_all(1'b1, 32'h18, 1'b0, 1'b0, 1'b1);
        tick();
        chk("bp_drain1_pc",    1, t_pc[1], 32'h14);
        chk("bp_drain1_ready", 1, {31'd0, t_ready[1]}, 32'd1);
        tick();
        chk("bp_drain2_pc",    1, t_pc[1], 32'h18);
        chk("bp_drain2_count", 1, {30'd0, t_count[1]}, 32'd1);
        drive_all(1'b0, 32'h0, 1'b0, 1'b0, 1'b1);
        tick();
        chk("bp_empty", 1, {31'd0, t_valid[1]}, 32'd0);

        // flush with both entries full and a pair offered on the flush cycle
        drive_all(1'b1, 32'h30, 1'b1, 1'b0, 1'b1);
        tick();
        drive_all(1'b1, 32'h34, 1'b1, 1'b0, 1'b1);
        tick();
        drive_all(1'b1, 32'h20, 1'b0, 1'b1, 1'b1);
        tick();
        for (int k = 0; k < 2; k++) begin
            chk("flush_valid", k, {31'd0, t_valid[k]}, 32'd0);
            chk("flush_inst",  k, t_inst[k], c_NOP);
            chk("flush_pc",    k, t_pc[k], 32'd0);
            chk("flush_count", k, {30'd0, t_count[k]}, 32'd0);
            chk("flush_ready", k, {31'd0, t_ready[k]}, 32'd1);
        end
        drive_all(1'b0, 32'h0, 1'b0, 1'b0, 1'b1);
        tick();
        chk("flush_no_0x20", 0, {31'd0, t_valid[0]}, 32'd0);

        // flush beats stall
        drive_all(1'b1, 32'h60, 1'b1, 1'b0, 1'b1);
        tick();
        drive_all(1'b1, 32'h64, 1'b1, 1'b0, 1'b1);
        tick();
        drive_all(1'b0, 32'h0, 1'b1, 1'b1, 1'b1);
        tick();
        chk("flush_stall_valid", 1, {31'd0, t_valid[1]}, 32'd0);
        chk("flush_stall_count", 1, {30'd0, t_count[1]}, 32'd0);

        // asynchronous reset mid-cycle
        drive_all(1'b1, 32'h40, 1'b0, 1'b0, 1'b1);
        tick();
        chk("pre_arst_pc", 1, t_pc[1], 32'h40);
        drive_all(1'b0, 32'h0, 1'b1, 1'b0, 1'b1);
        #2;
        i_reset = 1'b1;
        #1;
        for (int k = 0; k < 2; k++) begin
            chk("arst_valid", k, {31'd0, t_valid[k]}, 32'd0);
            chk("arst_inst",  k, t_inst[k], c_NOP);
            chk("arst_count", k, {30'd0, t_count[k]}, 32'd0);
        end
        tick();
        i_reset = 1'b0;
        drive_all(1'b0, 32'h0, 1'b0, 1'b0, 1'b1);
        tick();

        // combinational ready of the single-entry build
        drive_all(1'b1, 32'h50, 1'b0, 1'b0, 1'b1);
        tick();
        chk("ns_valid", 0, {31'd0, t_valid[0]}, 32'd1);
        drive_all(1'b0, 32'h0, 1'b0, 1'b0, 1'b0);
        #1;
        chk("ns_ready_low", 0, {31'd0, t_ready[0]}, 32'd0);
        d_ready = 2'b11;
        #1;
        chk("ns_ready_high", 0, {31'd0, t_ready[0]}, 32'd1);
        tick();

        repeat (3000) begin
            for (int k = 0; k < 2; k++) begin
                d_valid[k] = ($urandom_range(99) < 70);
                d_ready[k] = ($urandom_range(99) < 65);
                d_stall[k] = ($urandom_range(99) < 20);
                d_flush[k] = ($urandom_range(99) < 4);
                d_pc[k]    = {$urandom_range(32'h3FFF_FFFF), 2'b00};
                d_inst[k]  = $urandom;
            end
            tick();
        end

        drive_all(1'b0, 32'h0, 1'b0, 1'b0, 1'b1);
        repeat (3) tick();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
`default_nettype wire
